// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: three-state resolver for branches and JAL that issues a registered redirect/release pulse.
module branch_resolve_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_instr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            release_pulse,
  output logic            busy,
  output logic            misaligned,
  output logic            bad_funct3
);
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_instr, r_pc, r_rs1, r_rs2;
  logic            w_ctrl, w_jal, w_eq, w_lt, w_ltu, w_base, w_bad, w_taken;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm, w_target, w_next;
  always_comb begin
    w_ctrl   = ex_instr[6:0] == 7'b1100011 || ex_instr[6:0] == 7'b1101111;
    w_jal    = r_instr[6:0] == 7'b1101111;
    w_f3     = r_instr[14:12];
    w_eq     = r_rs1 == r_rs2;
    w_lt     = $signed(r_rs1) < $signed(r_rs2);
    w_ltu    = r_rs1 < r_rs2;
    w_bad    = !w_jal && w_f3[2:1] == 2'b01;
    // odd funct3 encodings are the negated form of the even one below them
    w_base   = w_f3[2:1] == 2'b00 ? w_eq : w_f3[2:1] == 2'b10 ? w_lt : w_ltu;
    w_taken  = w_jal || (!w_bad && (w_base ^ w_f3[0]));
    w_imm    = w_jal ? {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0}
                     : {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    w_target = r_pc + w_imm;
    w_next   = w_taken ? w_target : r_pc + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      release_pulse  <= 1'b0;
      busy           <= 1'b0;
      misaligned     <= 1'b0;
      bad_funct3     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (ex_valid && w_ctrl) begin
          r_instr <= ex_instr;
          r_pc    <= ex_pc;
          r_rs1   <= rs1_val;
          r_rs2   <= rs2_val;
          busy    <= 1'b1;
          r_state <= RESOLVE;
        end
        RESOLVE: begin
          redirect_valid <= w_taken;
          redirect_pc    <= w_next;
          release_pulse  <= 1'b1;
          misaligned     <= w_taken && w_target[1:0] != 2'b00;
          bad_funct3     <= w_bad;
          r_state        <= REDIRECT;
        end
        default: begin
          redirect_valid <= 1'b0;
          release_pulse  <= 1'b0;
          misaligned     <= 1'b0;
          bad_funct3     <= 1'b0;
          busy           <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a countdown-based reference model.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst, ex_valid, redirect_valid, release_pulse, busy, misaligned, bad_funct3;
  logic [31:0] ex_instr, ex_pc, rs1_val, rs2_val, redirect_pc;
  int          checks = 0, errors = 0;
  int          m_cnt = 0;
  logic        m_rv = 0, m_rel = 0, m_mis = 0, m_bad = 0, p_tk, p_bad;
  logic [31:0] m_pc = 0, p_nxt;

  branch_resolve_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .release_pulse(release_pulse), .busy(busy),
    .misaligned(misaligned), .bad_funct3(bad_funct3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_resolve(input logic [31:0] ins, pc, a, b,
                                      output logic tk, output logic [31:0] nxt, output logic bad);
    logic [31:0] imm;
    bad = 1'b0;
    if (ins[6:0] == 7'h6f) begin
      imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      tk  = 1'b1;
    end else begin
      imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      case (ins[14:12])
        3'd0: tk = a == b;
        3'd1: tk = a != b;
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        3'd7: tk = a >= b;
        default: begin tk = 1'b0; bad = 1'b1; end
      endcase
    end
    nxt = tk ? pc + imm : pc + 32'd4;
  endfunction

  // m_cnt: 0 idle, 2 resolving, 1 redirect cycle showing the pending result
  task automatic model_step();
    if (rst) begin
      m_cnt = 0; m_rv = 0; m_rel = 0; m_mis = 0; m_bad = 0; m_pc = 0;
    end else begin
      m_rv = 0; m_rel = 0; m_mis = 0; m_bad = 0;
      if (m_cnt == 2) begin
        m_rel = 1; m_rv = p_tk; m_pc = p_nxt; m_bad = p_bad;
        m_mis = p_tk && p_nxt[1:0] != 2'b00;
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_cnt = 0;
      end else if (ex_valid && (ex_instr[6:0] == 7'h63 || ex_instr[6:0] == 7'h6f)) begin
        ref_resolve(ex_instr, ex_pc, rs1_val, rs2_val, p_tk, p_nxt, p_bad);
        m_cnt = 2;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] ins, pc, a, b);
    @(negedge clk);
    rst = r; ex_valid = v; ex_instr = ins; ex_pc = pc; rs1_val = a; rs2_val = b;
    @(posedge clk);
    model_step();
    #1;
    check("busy", busy, m_cnt != 0);
    check("redirect_valid", redirect_valid, m_rv);
    check("release", release_pulse, m_rel);
    check("misaligned", misaligned, m_mis);
    check("bad_funct3", bad_funct3, m_bad);
    check("redirect_pc", redirect_pc, m_pc);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
  endfunction

  initial begin
    logic [31:0] ins, a, b, bne;
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, enc_b(3'd0, 13'd16), 32'h100, 32'd5, 32'd5);
    check("reset_busy", busy, 1'b0);
    check("reset_pc", redirect_pc, 32'h0);
    cycle(1'b0, 1'b1, enc_b(3'd0, 13'd16), 32'h100, 32'd5, 32'd5);
    idle();
    check("beq_valid", redirect_valid, 1'b1);
    check("beq_pc", redirect_pc, 32'h110);
    idle();
    check("beq_pc_hold", redirect_pc, 32'h110);
    cycle(1'b0, 1'b1, enc_b(3'd4, 13'd16), 32'h200, 32'hFFFFFFFF, 32'd1);
    idle();
    check("blt_taken", redirect_valid, 1'b1);
    idle();
    cycle(1'b0, 1'b1, enc_b(3'd6, 13'd16), 32'h200, 32'hFFFFFFFF, 32'd1);
    idle();
    check("bltu_not_taken", redirect_valid, 1'b0);
    check("bltu_pc", redirect_pc, 32'h204);
    idle();
    cycle(1'b0, 1'b1, enc_j(21'h1FFFF8), 32'h4, 32'h0, 32'h0);
    idle();
    check("jal_wrap", redirect_pc, 32'hFFFFFFFC);
    idle();
    cycle(1'b0, 1'b1, enc_b(3'd2, 13'd8), 32'h40, 32'd3, 32'd3);
    idle();
    check("bad_f3", bad_funct3, 1'b1);
    check("bad_f3_release", release_pulse, 1'b1);
    idle();
    cycle(1'b0, 1'b1, 32'h00208033, 32'h50, 32'd1, 32'd2);
    check("add_ignored", busy, 1'b0);
    cycle(1'b0, 1'b1, enc_b(3'd0, 13'd16), 32'h100, 32'd5, 32'd5);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("abort_busy", busy, 1'b0);
    repeat (3) idle();
    bne = enc_b(3'd1, 13'h1FFC);
    cycle(1'b0, 1'b1, bne, 32'h300, 32'd1, 32'd2);
    cycle(1'b0, 1'b1, bne, 32'h300, 32'd1, 32'd2);
    cycle(1'b0, 1'b1, bne, 32'h300, 32'd1, 32'd2);
    cycle(1'b0, 1'b1, bne, 32'h300, 32'd1, 32'd2);
    idle();
    check("b2b_release", release_pulse, 1'b1);
    check("b2b_pc", redirect_pc, 32'h2FC);
    idle();
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: ins[6:0] = 7'h63;
        3: ins[6:0] = 7'h6f;
        default: ;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ins, $urandom, a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
